// File: rtl/exec_wb_stage_if.sv
// Bundle between the execute/write-back stage and its neighbours.
// Those neighbours are the upstream issue logic and the 16x8 register file.
interface exec_wb_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [ADDR_W-1:0] in_rs;
    logic [ADDR_W-1:0] in_rt;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_imm;
    logic [ADDR_W-1:0] rf_read_addr_1;
    logic [ADDR_W-1:0] rf_read_addr_2;
    logic [DATA_W-1:0] rf_read_data_1;
    logic [DATA_W-1:0] rf_read_data_2;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_dest;
    logic [DATA_W-1:0] rf_write_data;
    logic              zero_flag;
    logic              carry_flag;
    logic              illegal_op;

    // Environment side: issues instructions and supplies register file read data
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        output rf_read_data_1, rf_read_data_2,
        input  in_ready, rf_read_addr_1, rf_read_addr_2,
        input  rf_write_en, rf_write_dest, rf_write_data,
        input  zero_flag, carry_flag, illegal_op
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        input  rf_read_data_1, rf_read_data_2,
        output in_ready, rf_read_addr_1, rf_read_addr_2,
        output rf_write_en, rf_write_dest, rf_write_data,
        output zero_flag, carry_flag, illegal_op
    );
endinterface

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage: single-cycle ALU ops, iterative shift-add multiply,
// registered register-file write port with forwarding of its own pending write.
module exec_wb_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           rst,
    exec_wb_stage_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_LI   = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic {IDLE, MUL} state_t;

    state_t state;
    state_t next_state;

    logic              in_ready;
    logic              accept;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum_ab;
    logic [DATA_W:0]   diff_ab;
    logic [DATA_W:0]   sum_imm;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_writes;
    logic              alu_illegal;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_dest_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              zero_q;
    logic              carry_q;
    logic              illegal_q;

    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] mul_acc;
    logic [DATA_W-1:0] mul_acc_next;
    logic [ADDR_W-1:0] mul_rd;
    logic [CNT_W-1:0]  mul_count;

    assign bus.rf_read_addr_1 = bus.in_rs;
    assign bus.rf_read_addr_2 = bus.in_rt;
    assign bus.in_ready       = in_ready;
    assign bus.rf_write_en    = wr_en_q;
    assign bus.rf_write_dest  = wr_dest_q;
    assign bus.rf_write_data  = wr_data_q;
    assign bus.zero_flag      = zero_q;
    assign bus.carry_flag     = carry_q;
    assign bus.illegal_op     = illegal_q;

    assign accept = bus.in_valid && in_ready;

    // Register 0 reads as zero; the write still sitting on the port beats the stale file copy
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (bus.in_rs != '0) begin
            op_a = (wr_en_q && wr_dest_q == bus.in_rs) ? wr_data_q : bus.rf_read_data_1;
        end
        if (bus.in_rt != '0) begin
            op_b = (wr_en_q && wr_dest_q == bus.in_rt) ? wr_data_q : bus.rf_read_data_2;
        end
    end

    always_comb begin
        sum_ab      = {1'b0, op_a} + {1'b0, op_b};
        diff_ab     = {1'b0, op_a} - {1'b0, op_b};
        sum_imm     = {1'b0, op_a} + {1'b0, bus.in_imm};
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_writes  = 1'b1;
        alu_illegal = 1'b0;
        case (bus.in_op)
            OP_NOP:  alu_writes = 1'b0;
            OP_ADD:  begin alu_res = sum_ab[DATA_W-1:0];  alu_carry = sum_ab[DATA_W];  end
            OP_SUB:  begin alu_res = diff_ab[DATA_W-1:0]; alu_carry = diff_ab[DATA_W]; end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, diff_ab[DATA_W]};
            OP_ADDI: begin alu_res = sum_imm[DATA_W-1:0]; alu_carry = sum_imm[DATA_W]; end
            OP_LI:   alu_res = bus.in_imm;
            OP_MUL:  alu_writes = 1'b0;
            default: begin alu_writes = 1'b0; alu_illegal = 1'b1; end
        endcase
    end

    assign mul_acc_next = mul_acc + (mul_b[0] ? mul_a : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && bus.in_op == OP_MUL) next_state = MUL;
            MUL:     if (mul_count == CNT_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    // Write port and flags; the last multiply step lands its product straight into the write registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_acc   <= '0;
            mul_rd    <= '0;
            mul_count <= '0;
        end else begin
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    illegal_q <= alu_illegal;
                    if (bus.in_op == OP_MUL) begin
                        mul_a     <= op_a;
                        mul_b     <= op_b;
                        mul_acc   <= '0;
                        mul_rd    <= bus.in_rd;
                        mul_count <= CNT_W'(DATA_W);
                    end else if (alu_writes && bus.in_rd != '0) begin
                        wr_en_q   <= 1'b1;
                        wr_dest_q <= bus.in_rd;
                        wr_data_q <= alu_res;
                        zero_q    <= (alu_res == '0);
                        carry_q   <= alu_carry;
                    end
                end
            end else begin
                mul_acc   <= mul_acc_next;
                mul_a     <= mul_a << 1;
                mul_b     <= mul_b >> 1;
                mul_count <= mul_count - CNT_W'(1);
                if (mul_count == CNT_W'(1) && mul_rd != '0) begin
                    wr_en_q   <= 1'b1;
                    wr_dest_q <= mul_rd;
                    wr_data_q <= mul_acc_next;
                    zero_q    <= (mul_acc_next == '0);
                    carry_q   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage: directed scenarios then random instructions, checked
// against an architectural register/flag model updated as each result retires.
module tb_exec_wb_stage;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef struct {
        int         cyc;
        logic [3:0] dest;
        logic [7:0] data;
        logic       z;
        logic       c;
    } exp_t;

    logic clk;
    logic rst;
    exec_wb_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    exec_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   tests = 0;
    int   failed = 0;
    int   cycle = 0;
    int   ready_from = 0;
    int   illegal_at = -1;
    exp_t wq[$];
    int   arch_regs [16];
    logic m_zero = 1'b0;
    logic m_carry = 1'b0;
    logic [7:0] rf_mem [16];
    logic loaded = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment: reg[i]=i once during the first reset, then commits on the edge
    always @(posedge clk) begin
        if (!rst) begin
            if (!loaded) begin
                for (int i = 0; i < 16; i++) rf_mem[i] <= 8'(i);
                loaded <= 1'b1;
            end
        end else if (bus.rf_write_en) begin
            rf_mem[bus.rf_write_dest] <= bus.rf_write_data;
        end
    end

    assign bus.rf_read_data_1 = rf_mem[bus.rf_read_addr_1];
    assign bus.rf_read_data_2 = rf_mem[bus.rf_read_addr_2];

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_alu(input int op, input int a, input int b, input int imm,
                                    output int res, output logic carry, output logic writes);
        res = 0;
        carry = 1'b0;
        writes = (op >= 1 && op <= 9);
        case (op)
            1: begin res = (a + b) % 256; carry = (a + b) > 255; end
            2: begin res = (a - b + 256) % 256; carry = a < b; end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = (a < b) ? 1 : 0;
            7: begin res = (a + imm) % 256; carry = (a + imm) > 255; end
            8: res = imm;
            9: res = (a * b) % 256;
            default: res = 0;
        endcase
    endfunction

    task automatic apply_stimulus(input int op, input int rs, input int rt, input int rd,
                                  input int imm, output int waited);
        int   a;
        int   b;
        int   res;
        logic cy;
        logic wr;
        int   edge_n;
        exp_t e;
        @(negedge clk);
        bus.in_op    = 4'(op);
        bus.in_rs    = 4'(rs);
        bus.in_rt    = 4'(rt);
        bus.in_rd    = 4'(rd);
        bus.in_imm   = 8'(imm);
        bus.in_valid = 1'b1;
        waited = 0;
        #1;
        while (bus.in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            check_output("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        check_output("rd_addr_1", 32'(bus.rf_read_addr_1), 32'(rs));
        check_output("rd_addr_2", 32'(bus.rf_read_addr_2), 32'(rt));
        a = (rs == 0) ? 0 : arch_regs[rs];
        b = (rt == 0) ? 0 : arch_regs[rt];
        ref_alu(op, a, b, imm, res, cy, wr);
        edge_n = cycle + 1;
        if (op >= 10) illegal_at = edge_n;
        if (op == 9) ready_from = edge_n + DATA_W;
        if (wr && rd != 0) begin
            e.cyc  = (op == 9) ? edge_n + DATA_W : edge_n;
            e.dest = 4'(rd);
            e.data = 8'(res);
            e.z    = (res == 0);
            e.c    = cy;
            wq.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // Retirement monitor: every cycle compares the write port, flags, illegal pulse and ready
    initial begin
        exp_t e;
        logic exp_we;
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            if (rst) begin
                exp_we = (wq.size() > 0) && (wq[0].cyc == cycle);
                if (exp_we) begin
                    e = wq.pop_front();
                    m_zero  = e.z;
                    m_carry = e.c;
                    arch_regs[e.dest] = int'(e.data);
                    check_output("wr_dest", 32'(bus.rf_write_dest), 32'(e.dest));
                    check_output("wr_data", 32'(bus.rf_write_data), 32'(e.data));
                end
                check_output("wr_en", 32'(bus.rf_write_en), 32'(exp_we));
                check_output("zero_flag", 32'(bus.zero_flag), 32'(m_zero));
                check_output("carry_flag", 32'(bus.carry_flag), 32'(m_carry));
                check_output("illegal_op", 32'(bus.illegal_op), 32'(illegal_at == cycle));
                check_output("in_ready", 32'(bus.in_ready), 32'(cycle >= ready_from));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int last_rd;
        int op;
        logic [7:0] saved;
        for (int i = 0; i < 16; i++) arch_regs[i] = i;
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_rs = '0;
        bus.in_rt = '0;
        bus.in_rd = '0;
        bus.in_imm = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_output("rst_wr_en", 32'(bus.rf_write_en), 32'd0);
        check_output("rst_dest", 32'(bus.rf_write_dest), 32'd0);
        check_output("rst_data", 32'(bus.rf_write_data), 32'd0);
        check_output("rst_zero", 32'(bus.zero_flag), 32'd0);
        check_output("rst_carry", 32'(bus.carry_flag), 32'd0);
        check_output("rst_illegal", 32'(bus.illegal_op), 32'd0);
        check_output("rst_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        apply_stimulus(1, 3, 4, 5, 0, w);
        apply_stimulus(1, 2, 2, 6, 0, w);
        apply_stimulus(2, 6, 1, 7, 0, w);
        apply_stimulus(2, 1, 2, 8, 0, w);
        apply_stimulus(8, 0, 0, 0, 8'h55, w);
        apply_stimulus(7, 0, 0, 9, 8'hFF, w);
        apply_stimulus(9, 13, 15, 10, 0, w);
        apply_stimulus(1, 10, 1, 11, 0, w);
        check_output("mul_stall_cycles", 32'(w), 32'(DATA_W));
        apply_stimulus(8, 0, 0, 1, 8'h80, w);
        apply_stimulus(8, 0, 0, 2, 8'h80, w);
        apply_stimulus(1, 1, 2, 3, 0, w);
        apply_stimulus(12, 1, 2, 4, 0, w);
        idle(3);
        check_output("r0_kept", 32'(rf_mem[0]), 32'h00);
        check_output("r5_add", 32'(rf_mem[5]), 32'h07);
        check_output("r6_add", 32'(rf_mem[6]), 32'h04);
        check_output("r7_fwd_sub", 32'(rf_mem[7]), 32'h03);
        check_output("r8_borrow", 32'(rf_mem[8]), 32'hFF);
        check_output("r9_addi_r0", 32'(rf_mem[9]), 32'hFF);
        check_output("r10_mul", 32'(rf_mem[10]), 32'hC3);
        check_output("r11_fwd_mul", 32'(rf_mem[11]), 32'hC4);
        check_output("r3_overflow", 32'(rf_mem[3]), 32'h00);
        check_output("r4_illegal", 32'(rf_mem[4]), 32'h04);

        saved = rf_mem[12];
        apply_stimulus(9, 13, 15, 12, 0, w);
        idle(3);
        rst = 1'b0;
        #1;
        check_output("abort_wr_en", 32'(bus.rf_write_en), 32'd0);
        check_output("abort_data", 32'(bus.rf_write_data), 32'd0);
        check_output("abort_dest", 32'(bus.rf_write_dest), 32'd0);
        check_output("abort_zero", 32'(bus.zero_flag), 32'd0);
        check_output("abort_carry", 32'(bus.carry_flag), 32'd0);
        check_output("abort_illegal", 32'(bus.illegal_op), 32'd0);
        wq.delete();
        m_zero = 1'b0;
        m_carry = 1'b0;
        illegal_at = -1;
        ready_from = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("abort_ready", 32'(bus.in_ready), 32'd1);
        idle(12);
        check_output("abort_no_write", 32'(rf_mem[12]), 32'(saved));

        last_rd = 1;
        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 9));
            apply_stimulus(op,
                           ($urandom_range(0, 2) == 0) ? last_rd : int'($urandom_range(0, 15)),
                           ($urandom_range(0, 2) == 0) ? last_rd : int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), w);
            last_rd = int'(bus.in_rd);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(12);
        check_output("queue_drained", 32'(wq.size()), 32'd0);
        for (int i = 1; i < 16; i++) check_output("final_reg", 32'(rf_mem[i]), 32'(arch_regs[i]));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Execute/write-back stage directly upstream of the 16x8 register file.
- Accepts decoded ALU instructions over a valid/ready handshake and drives the register file's two read-address ports.
- Computes results, including an iterative multi-cycle multiply, and drives the register file's write port one cycle later.
- Forwards its own pending write so back-to-back dependent instructions see correct operands.

Parameters:
DATA_W, 8, operand/result width; equals register file data width
ADDR_W, 4, register address width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  instruction present
in_ready  output  1  stage can accept this cycle
in_op  input  4  opcode
in_rs  input  ADDR_W  source A register
in_rt  input  ADDR_W  source B register
in_rd  input  ADDR_W  destination register
in_imm  input  DATA_W  immediate
rf_read_addr_1  output  ADDR_W  combinational copy of in_rs
rf_read_addr_2  output  ADDR_W  combinational copy of in_rt
rf_read_data_1  input  DATA_W  register file read data A
rf_read_data_2  input  DATA_W  register file read data B
rf_write_en  output  1  register file write enable (registered)
rf_write_dest  output  ADDR_W  write address (registered)
rf_write_data  output  DATA_W  write data (registered)
zero_flag  output  1  last written result == 0
carry_flag  output  1  carry/borrow of last written result
illegal_op  output  1  one-cycle pulse on accepted undefined opcode

Behaviour:
- Reset (rst low, async): state IDLE. in_ready=1 after reset; rf_write_en, rf_write_dest, rf_write_data, zero_flag, carry_flag, illegal_op = 0. An in-flight MUL is aborted with no write.
- Accept: in_valid && in_ready at a rising edge. in_ready = (state==IDLE).
- Opcodes (A = operand A, B = operand B, all arithmetic mod 2^DATA_W):
  - 0 NOP: no write.
  - 1 ADD: A+B, carry = carry-out.
  - 2 SUB: A-B, carry = borrow (A<B).
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 SLTU: 1 if A<B unsigned, else 0.
  - 7 ADDI: A+imm, carry = carry-out.
  - 8 LI: imm.
  - 9 MUL: low DATA_W bits of A*B.
  - 10-15: no write; illegal_op pulses for one cycle after the accept edge.
- Carry is 0 for all ops other than ADD, SUB, ADDI.
- Operands: A = (in_rs==0) ? 0 : (pending write to in_rs ? rf_write_data : rf_read_data_1). B is the same rule using in_rt and rf_read_data_2.
  - "Pending write to X" means rf_write_en && rf_write_dest==X in the accept cycle.
- Single-cycle ops accepted at edge E: rf_write_en=1 during cycle E..E+1; the register file commits at edge E+1.
  - rf_write_en deasserts after one cycle unless another write follows.
  - Back-to-back accepts are allowed every cycle.
- rd=0: result computed but rf_write_en stays 0; flags unchanged.
- Flags: registered together with rf_write_data, only when rf_write_en is set.
- State machine IDLE/MUL:
  - MUL accepted at E: latch A and B, clear the accumulator, counter = DATA_W, go to MUL.
  - MUL performs one shift-add step per edge (E+1..E+DATA_W), decrementing the counter.
  - At edge E+DATA_W: result is loaded into the write registers, state returns to IDLE.
  - in_ready=0 for the DATA_W cycles after E; it is 1 again in the cycle rf_write_en is high, so forwarding covers the dependent op.
- During MUL, upstream holds its instruction (standard valid/ready). rf_read_addr_* keep tracking the in_* inputs. No write pulses occur during MUL.
- Reset mid-MUL: outputs return to reset values immediately; no partial write.

Test Plan:
1. Reset; register file preloaded with reg[i]=i. ADD rs=3 rt=4 rd=5 → rf_write_en=1, dest=5, data=7 one cycle after accept; zero=0, carry=0.
2. Back-to-back: ADD rs=2 rt=2 rd=6, next cycle SUB rs=6 rt=1 rd=7 → second result 3 (forwarded 4-1). Then SUB rs=1 rt=2 rd=8 → data=0xFF, carry=1, zero=0.
3. Writes to rd=0 are suppressed and reads of reg 0 return 0: LI imm=0x55 rd=0 → rf_write_en stays 0. Then ADDI rs=0 imm=0xFF rd=9 → data=0xFF, carry=0.
4. MUL rs=13 rt=15 rd=10 with a following ADD held valid → in_ready low 8 cycles; write data=0xC3 (195). Then ADD rs=10 rt=1 rd=11 accepted → data=0xC4 via forwarding.
5. Overflow and zero: LI 0x80 rd=1, LI 0x80 rd=2, ADD rs=1 rt=2 rd=3 → data=0x00, zero=1, carry=1. Opcode 12 → illegal_op one-cycle pulse, no write.
6. Assert rst low four cycles into a MUL → all outputs 0 immediately, in_ready=1 after release, no write observed.
